// File: rtl/ds1302_pkg.sv
`default_nettype none
// ============================================================================
// ds1302_pkg : shared types and constants for the DS1302 access scheduler
// Revision   : 1.0
// ============================================================================
package ds1302_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } sched_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } ds_op_t;

    // Field positions inside the 64-bit clock burst
    localparam int SEC_LSB = 0;
    localparam int MIN_LSB = 8;
    localparam int HR_LSB  = 16;
    localparam int CH_BIT  = 7;

    localparam int DEF_POLL_CYCLES    = 500000;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int DEF_GAP_CYCLES     = 4;

endpackage
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// ============================================================================
// btn_edge_sync : 2-FF synchronizer plus registered falling-edge press pulse
// Revision      : 1.0
// ============================================================================
module btn_edge_sync (
    input  logic clk,
    input  logic rstn,
    input  logic btn_n,
    output logic press
);

    // Reset to the released (high) level so leaving reset never looks like a press
    logic [2:0] sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync  <= 3'b111;
            press <= 1'b0;
        end else begin
            sync  <= {sync[1:0], btn_n};
            press <= sync[2] & ~sync[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ds1302_access_scheduler.sv
`default_nettype none
// ============================================================================
// ds1302_access_scheduler : arbitrates button and poll requests onto the
//                           single DS1302 controller, with timeout and snapshot
// Revision                : 1.0
// ============================================================================
module ds1302_access_scheduler
    import ds1302_pkg::*;
#(
    parameter int POLL_CYCLES    = DEF_POLL_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rd_btn,
    input  logic        wr_btn,
    input  logic        ctl_busy,
    input  logic        ctl_done,
    input  logic [63:0] ctl_data,
    output logic        rd_start,
    output logic        wr_start,
    output logic [63:0] time_snapshot,
    output logic        snap_valid,
    output logic        busy,
    output logic        err_timeout
);

    localparam int POLL_W = (POLL_CYCLES > 1)    ? $clog2(POLL_CYCLES)    : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1)     ? $clog2(GAP_CYCLES)     : 1;

    sched_state_t      state;
    ds_op_t            op;
    logic              rd_press;
    logic              wr_press;
    logic              rd_pend;
    logic              wr_pend;
    logic              poll_pend;
    logic [POLL_W-1:0] poll_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              poll_hit;

    btn_edge_sync u_rd_sync (
        .clk   (clk),
        .rstn  (rstn),
        .btn_n (rd_btn),
        .press (rd_press)
    );

    btn_edge_sync u_wr_sync (
        .clk   (clk),
        .rstn  (rstn),
        .btn_n (wr_btn),
        .press (wr_press)
    );

    assign poll_hit = (poll_cnt == POLL_W'(POLL_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            op            <= OP_RD;
            rd_pend       <= 1'b0;
            wr_pend       <= 1'b0;
            poll_pend     <= 1'b0;
            poll_cnt      <= '0;
            to_cnt        <= '0;
            gap_cnt       <= '0;
            rd_start      <= 1'b0;
            wr_start      <= 1'b0;
            time_snapshot <= 64'd0;
            snap_valid    <= 1'b0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            rd_start <= 1'b0;
            wr_start <= 1'b0;
            poll_cnt <= poll_hit ? '0 : poll_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (wr_pend) begin
                        op       <= OP_WR;
                        wr_pend  <= 1'b0;
                        wr_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end else if (rd_pend || poll_pend) begin
                        // One burst read serves both the button and the poll
                        op        <= OP_RD;
                        rd_pend   <= 1'b0;
                        poll_pend <= 1'b0;
                        rd_start  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (ctl_done) begin
                        err_timeout <= 1'b0;
                        if (op == OP_RD) begin
                            time_snapshot <= ctl_data;
                            snap_valid    <= 1'b1;
                        end else begin
                            rd_pend <= 1'b1;
                        end
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (state == S_WAIT_BUSY && ctl_busy)
                            state <= S_WAIT_DONE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            // New requests override a same-cycle grant clear so none is lost
            if (rd_press) rd_pend   <= 1'b1;
            if (wr_press) wr_pend   <= 1'b1;
            if (poll_hit) poll_pend <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ds1302_access_scheduler.sv
`default_nettype none
// ============================================================================
// tb_ds1302_access_scheduler : directed bench with a reactive controller model
// Revision                   : 1.0
// ============================================================================
module tb_ds1302_access_scheduler;

    localparam logic [63:0] DATA_A = 64'h0000_0000_0012_3456;
    localparam logic [63:0] DATA_B = 64'h0000_0000_0059_5923;
    localparam logic [63:0] DATA_C = 64'h0000_0000_0007_0809;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        rd_btn = 1'b1;
    logic        wr_btn = 1'b1;
    logic        ctl_busy;
    logic        ctl_done;
    logic [63:0] ctl_data = DATA_A;
    logic        rd_start;
    logic        wr_start;
    logic [63:0] time_snapshot;
    logic        snap_valid;
    logic        busy;
    logic        err_timeout;

    int passed = 0;
    int total  = 0;
    int edge_k = 0;
    int rd_cnt, wr_cnt, rd_e1, rd_e2, wr_e1;
    int mode = 0;   // 0: busy 20 cycles then done, 1: never responds, 2: done without busy
    int m_cnt;

    ds1302_access_scheduler #(
        .POLL_CYCLES    (100),
        .TIMEOUT_CYCLES (64),
        .GAP_CYCLES     (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .rd_btn        (rd_btn),
        .wr_btn        (wr_btn),
        .ctl_busy      (ctl_busy),
        .ctl_done      (ctl_done),
        .ctl_data      (ctl_data),
        .rd_start      (rd_start),
        .wr_start      (wr_start),
        .time_snapshot (time_snapshot),
        .snap_valid    (snap_valid),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt    <= 0;
            ctl_busy <= 1'b0;
            ctl_done <= 1'b0;
        end else begin
            ctl_done <= 1'b0;
            if (m_cnt == 0) begin
                if (rd_start || wr_start) begin
                    if (mode == 0) begin
                        m_cnt    <= 1;
                        ctl_busy <= 1'b1;
                    end else if (mode == 2) begin
                        m_cnt <= 1;
                    end
                end
            end else if (mode == 2 || m_cnt == 20) begin
                ctl_busy <= 1'b0;
                ctl_done <= 1'b1;
                m_cnt    <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; rd_e1 = 0; rd_e2 = 0; wr_e1 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_k++;
        if (rd_start) begin
            rd_cnt++;
            if (rd_cnt == 1) rd_e1 = edge_k;
            else if (rd_cnt == 2) rd_e2 = edge_k;
        end
        if (wr_start) begin
            wr_cnt++;
            if (wr_cnt == 1) wr_e1 = edge_k;
        end
    endtask

    task automatic do_reset();
        rd_btn = 1'b1;
        wr_btn = 1'b1;
        mode   = 0;
        @(posedge clk);
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        edge_k = 0;
        clear_counts();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rd_start !== 1'b0) $display("FAIL reset_rd_start got %b want 0", rd_start); else passed++;
        total++; if (wr_start !== 1'b0) $display("FAIL reset_wr_start got %b want 0", wr_start); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (err_timeout !== 1'b0) $display("FAIL reset_err got %b want 0", err_timeout); else passed++;
        total++; if (snap_valid !== 1'b0) $display("FAIL reset_snap_valid got %b want 0", snap_valid); else passed++;
        total++; if (time_snapshot !== 64'd0) $display("FAIL reset_snapshot got %h want 0", time_snapshot); else passed++;
        while (edge_k < 5) step();
        total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else passed++;
    endtask

    // Continues straight on from test_reset so the poll phase is known
    task automatic test_poll();
        ctl_data = DATA_A;
        while (edge_k < 230) begin
            step();
            if (edge_k == 50) begin
                total++; if (snap_valid !== 1'b0) $display("FAIL poll_early_valid got %b want 0", snap_valid); else passed++;
            end
            if (edge_k == 100) begin
                total++; if (rd_start !== 1'b0) $display("FAIL poll_wrap_edge_start got %b want 0", rd_start); else passed++;
            end
        end
        total++; if (rd_cnt !== 2) $display("FAIL poll_rd_count got %0d want 2", rd_cnt); else passed++;
        total++; if (rd_e1 !== 101) $display("FAIL poll_first_edge got %0d want 101", rd_e1); else passed++;
        total++; if (rd_e2 !== 201) $display("FAIL poll_second_edge got %0d want 201", rd_e2); else passed++;
        total++; if (wr_cnt !== 0) $display("FAIL poll_wr_count got %0d want 0", wr_cnt); else passed++;
        total++; if (time_snapshot !== DATA_A) $display("FAIL poll_snapshot got %h want %h", time_snapshot, DATA_A); else passed++;
        total++; if (snap_valid !== 1'b1) $display("FAIL poll_snap_valid got %b want 1", snap_valid); else passed++;
    endtask

    task automatic test_timeout();
        clear_counts();
        mode = 1;
        while (edge_k < 430) begin
            step();
            if (edge_k == 300) begin
                total++; if (rd_start !== 1'b0) $display("FAIL to_pre_start got %b want 0", rd_start); else passed++;
            end
            if (edge_k == 301) begin
                total++; if (rd_start !== 1'b1) $display("FAIL to_start got %b want 1", rd_start); else passed++;
            end
            if (edge_k == 365) begin
                total++; if (err_timeout !== 1'b0) $display("FAIL to_err_early got %b want 0", err_timeout); else passed++;
            end
            if (edge_k == 366) begin
                total++; if (err_timeout !== 1'b1) $display("FAIL to_err_set got %b want 1", err_timeout); else passed++;
            end
            if (edge_k == 369) begin
                total++; if (busy !== 1'b1) $display("FAIL to_gap_busy got %b want 1", busy); else passed++;
            end
            if (edge_k == 370) begin
                total++; if (busy !== 1'b0) $display("FAIL to_idle_busy got %b want 0", busy); else passed++;
                total++; if (time_snapshot !== DATA_A) $display("FAIL to_snapshot_kept got %h want %h", time_snapshot, DATA_A); else passed++;
                mode     = 0;
                ctl_data = DATA_B;
            end
            if (edge_k == 400) begin
                total++; if (err_timeout !== 1'b1) $display("FAIL to_err_sticky got %b want 1", err_timeout); else passed++;
            end
        end
        total++; if (err_timeout !== 1'b0) $display("FAIL to_err_cleared got %b want 0", err_timeout); else passed++;
        total++; if (time_snapshot !== DATA_B) $display("FAIL to_new_snapshot got %h want %h", time_snapshot, DATA_B); else passed++;
        total++; if (rd_cnt !== 2) $display("FAIL to_rd_count got %0d want 2", rd_cnt); else passed++;
    endtask

    task automatic test_write();
        do_reset();
        ctl_data = DATA_A;
        while (edge_k < 95) begin
            if (edge_k == 9)  wr_btn = 1'b0;
            if (edge_k == 19) wr_btn = 1'b1;
            step();
        end
        total++; if (wr_cnt !== 1) $display("FAIL wr_count got %0d want 1", wr_cnt); else passed++;
        total++; if (wr_e1 !== 14) $display("FAIL wr_edge got %0d want 14", wr_e1); else passed++;
        total++; if (rd_cnt !== 1) $display("FAIL wr_followup_rd_count got %0d want 1", rd_cnt); else passed++;
        total++; if (rd_e1 !== 41) $display("FAIL wr_followup_rd_edge got %0d want 41", rd_e1); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL wr_end_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_both();
        do_reset();
        while (edge_k < 95) begin
            if (edge_k == 9)  begin rd_btn = 1'b0; wr_btn = 1'b0; end
            if (edge_k == 12) begin rd_btn = 1'b1; wr_btn = 1'b1; end
            step();
        end
        total++; if (wr_cnt !== 1) $display("FAIL both_wr_count got %0d want 1", wr_cnt); else passed++;
        total++; if (wr_e1 !== 14) $display("FAIL both_wr_edge got %0d want 14", wr_e1); else passed++;
        total++; if (rd_cnt !== 1) $display("FAIL both_rd_count got %0d want 1", rd_cnt); else passed++;
        total++; if (rd_e1 !== 41) $display("FAIL both_rd_edge got %0d want 41", rd_e1); else passed++;
    endtask

    task automatic test_merge();
        do_reset();
        while (edge_k < 95) begin
            if (edge_k == 9)  rd_btn = 1'b0;
            if (edge_k == 12) rd_btn = 1'b1;
            // Five presses while the first read is in flight
            if (edge_k >= 17 && edge_k < 37) rd_btn = ((edge_k - 17) % 4) < 2 ? 1'b0 : 1'b1;
            if (edge_k == 37) rd_btn = 1'b1;
            step();
        end
        total++; if (rd_cnt !== 2) $display("FAIL merge_rd_count got %0d want 2", rd_cnt); else passed++;
        total++; if (rd_e1 !== 14) $display("FAIL merge_first_edge got %0d want 14", rd_e1); else passed++;
        total++; if (rd_e2 !== 41) $display("FAIL merge_second_edge got %0d want 41", rd_e2); else passed++;
        total++; if (wr_cnt !== 0) $display("FAIL merge_wr_count got %0d want 0", wr_cnt); else passed++;
    endtask

    task automatic test_short();
        do_reset();
        mode     = 2;
        ctl_data = DATA_C;
        while (edge_k < 40) begin
            if (edge_k == 9)  rd_btn = 1'b0;
            if (edge_k == 12) rd_btn = 1'b1;
            step();
            if (edge_k == 20) begin
                total++; if (time_snapshot !== DATA_C) $display("FAIL short_snapshot got %h want %h", time_snapshot, DATA_C); else passed++;
                total++; if (busy !== 1'b1) $display("FAIL short_gap_busy got %b want 1", busy); else passed++;
            end
            if (edge_k == 21) begin
                total++; if (busy !== 1'b0) $display("FAIL short_idle_busy got %b want 0", busy); else passed++;
            end
        end
        total++; if (rd_cnt !== 1) $display("FAIL short_rd_count got %0d want 1", rd_cnt); else passed++;
        mode = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ctl_data = DATA_A;
        while (edge_k < 65) begin
            if (edge_k == 9)  rd_btn = 1'b0;
            if (edge_k == 12) rd_btn = 1'b1;
            if (edge_k == 49) rd_btn = 1'b0;
            if (edge_k == 52) rd_btn = 1'b1;
            if (edge_k == 59) rd_btn = 1'b0;
            if (edge_k == 62) rd_btn = 1'b1;
            step();
        end
        total++; if (busy !== 1'b1) $display("FAIL mid_pre_busy got %b want 1", busy); else passed++;
        total++; if (snap_valid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", snap_valid); else passed++;
        rstn = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL mid_async_busy got %b want 0", busy); else passed++;
        total++; if (snap_valid !== 1'b0) $display("FAIL mid_async_valid got %b want 0", snap_valid); else passed++;
        total++; if (time_snapshot !== 64'd0) $display("FAIL mid_async_snapshot got %h want 0", time_snapshot); else passed++;
        total++; if ({rd_start, wr_start, err_timeout} !== 3'b000) $display("FAIL mid_async_flags got %b want 000", {rd_start, wr_start, err_timeout}); else passed++;
        clear_counts();
        repeat (3) step();
        #1 rstn = 1'b1;
        edge_k = 0;
        while (edge_k < 90) step();
        total++; if (rd_cnt !== 0) $display("FAIL mid_after_rd_count got %0d want 0", rd_cnt); else passed++;
        total++; if (wr_cnt !== 0) $display("FAIL mid_after_wr_count got %0d want 0", wr_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_after_busy got %b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_poll();
        test_timeout();
        test_write();
        test_both();
        test_merge();
        test_short();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ds1302_access_scheduler.md
Name: ds1302_access_scheduler

Overview:
Sequences every access to the DS1302 serial controller, which is a single shared resource. Three requesters compete for it: the write button, the read button and a free-running periodic poll. The block grants one at a time, issues a single-cycle start pulse, waits for the controller's busy/done handshake with a timeout, and latches each completed 64-bit burst read into a stable snapshot for the display path. It sits between the button and time-setting logic and the DS1302 controller, in the clk1 domain.

Parameters:
POLL_CYCLES, 500000, clk cycles between automatic burst reads (0.5 s at 1 MHz); legal 16..2^24.
TIMEOUT_CYCLES, 4096, maximum cycles spent in WAIT_BUSY or WAIT_DONE before the transfer is abandoned.
GAP_CYCLES, 4, idle cycles after each transfer, guaranteeing CE-inactive time (tCWH).

Ports:
clk  in  1  system clock (clk1, 1 MHz); all logic on the rising edge.
rstn  in  1  reset, asynchronous, active-low.
rd_btn  in  1  raw read push-button, active-low, asynchronous.
wr_btn  in  1  raw write push-button, active-low, asynchronous.
ctl_busy  in  1  controller transfer in progress.
ctl_done  in  1  one-cycle pulse when the controller finishes a transfer.
ctl_data  in  64  controller burst-read data; valid in the ctl_done cycle.
rd_start  out  1  one-cycle pulse that starts a burst read.
wr_start  out  1  one-cycle pulse that starts a burst write.
time_snapshot  out  64  last successfully read burst.
snap_valid  out  1  sticky; set by the first successful read.
busy  out  1  high in every state except IDLE.
err_timeout  out  1  sticky flag: last transfer timed out.

Behaviour:
- Reset: every output is 0, time_snapshot is 0, pending flags are cleared, the poll counter is 0 and the FSM is in IDLE. A reset asserted mid-transfer aborts immediately; no start pulse is ever emitted while rstn is low.
- Buttons: each passes through a 2-FF synchronizer, then a falling-edge detector, giving a 1-cycle press pulse. A press sets rd_pend or wr_pend. Flags are one-deep: repeat presses while a flag is pending merge into it. Presses during a transfer are pended, not dropped.
- Poll counter: free-runs 0..POLL_CYCLES-1 and wraps. At the wrap it sets poll_pend, regardless of FSM state.
- Arbitration in IDLE, fixed priority: wr_pend first, then rd_pend, then poll_pend. A read grant clears both rd_pend and poll_pend, because one read serves both. A write grant clears only wr_pend.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
  - IDLE -> ISSUE when any flag is pending; the granted operation is latched.
  - ISSUE: exactly one cycle; rd_start or wr_start is high as a Moore output. Always goes to WAIT_BUSY.
  - WAIT_BUSY -> WAIT_DONE on ctl_busy=1.
  - WAIT_DONE -> GAP on ctl_done=1.
  - A ctl_done arriving in WAIT_BUSY is accepted as completion (covers very short transfers).
  - GAP: lasts GAP_CYCLES cycles, then -> IDLE.
- Timeout: a counter clears on entry to WAIT_BUSY and counts in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES-1: err_timeout <= 1, go to GAP, snapshot unchanged.
- Completion:
  - Read: in the ctl_done cycle, time_snapshot <= ctl_data, snap_valid <= 1, err_timeout <= 0.
  - Write: err_timeout <= 0 and rd_pend <= 1, so the display refreshes after the write.
- Latency: a button sampled low at edge 1 with the FSM in IDLE gives the start pulse in the cycle after edge 5 (sync 2 + edge 1 + pend 1 + grant 1).
- Simultaneous events:
  - Both buttons in the same cycle: write first, then read.
  - Poll wrap in the same cycle as a read press: a single read.
  - ctl_done in the same cycle as the timeout terminal count: done wins and no error is flagged.
- ctl_done outside WAIT_BUSY/WAIT_DONE is ignored.

Decomposition:
- Package ds1302_pkg holds:
  - the state enum sched_state_t and op enum ds_op_t {OP_RD, OP_WR};
  - burst-layout constants SEC_LSB=0, MIN_LSB=8, HR_LSB=16, CH_BIT=7;
  - default parameter values.
- Sub-module btn_edge_sync (2-FF synchronizer plus falling-edge pulse), instantiated once per button.

Test Plan:
1. Reset released, POLL_CYCLES=100, controller model with busy 20 cycles then done and ctl_data=64'h0000_0000_0012_3456 -> rd_start pulses at cycles 100 and 200; snapshot=...123456 and snap_valid=1 after the first done.
2. wr_btn low for 10 cycles at cycle 10 -> exactly one wr_start 5 cycles later; after done + GAP, one rd_start; no second wr_start.
3. rd_btn and wr_btn pressed in the same cycle -> wr_start first, a single rd_start after GAP; no third start.
4. Controller never asserts busy, TIMEOUT_CYCLES=64 -> err_timeout=1 64 cycles after rd_start; snapshot unchanged; FSM returns to IDLE after 4 gap cycles; next good read clears err_timeout.
5. Five rd_btn presses during one 20-cycle transfer -> exactly one extra read issued.
6. rstn pulsed low while in WAIT_DONE -> all outputs 0 asynchronously, pendings cleared; no start pulse until a new request arrives.
